// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch/PC sequencer: FSM state encoding,
// default widths, reset vector and a generic two's-complement sign extender.
package pc_seq_pkg;

   localparam int unsigned ADDR_W_DEF    = 16;
   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned OFF_W_DEF     = 9;
   localparam logic [15:0] RESET_VEC_DEF = 16'h3000;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      ISSUE   = 2'b10,
      RESOLVE = 2'b11
   } state_t;

   // Sign-extends the low 'width' bits of val to 32 bits; callers cast down.
   function automatic logic [31:0] sext32(input logic [31:0] val, input int unsigned width);
      logic [31:0] w_shl;
      w_shl = val << (32 - width);
      return $signed(w_shl) >>> (32 - width);
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC computation: pc+1 for fall-through, pc+1+sext(offset) for a taken
// branch. Purely combinational; all sums wrap modulo 2^ADDR_W.
module pc_next_calc
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned OFF_W  = OFF_W_DEF
)(
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_taken,
   input  logic [OFF_W-1:0]  i_off,
   output logic [ADDR_W-1:0] o_pc_next
);

   logic [ADDR_W-1:0] w_off_ext;
   logic [ADDR_W-1:0] w_pc_inc;

   assign w_off_ext = ADDR_W'(sext32(32'(i_off), OFF_W));
   assign w_pc_inc  = i_pc + ADDR_W'(1);
   assign o_pc_next = i_taken ? (w_pc_inc + w_off_ext) : w_pc_inc;

endmodule

// File: rtl/pc_seq.sv
// Fetch/PC sequencer: one instruction in flight (REQ -> ISSUE -> RESOLVE).
// Optional taken-branch counter enabled by defining PC_SEQ_BR_CNT_EN.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DEF,
   parameter int unsigned       DATA_W    = DATA_W_DEF,
   parameter int unsigned       OFF_W     = OFF_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
)(
   input  logic              clka,
   input  logic              reset_in,
   output logic              imem_req_out,
   output logic [ADDR_W-1:0] imem_addr_out,
   input  logic              imem_ack_in,
   input  logic [DATA_W-1:0] imem_rdata_in,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid_out,
   input  logic              instr_ready_in,
   input  logic              br_valid_in,
   input  logic              pc_ctl_0_in,
   input  logic [OFF_W-1:0]  br_off_in,
   output logic [ADDR_W-1:0] pc_out,
`ifdef PC_SEQ_BR_CNT_EN
   output logic [15:0]       br_taken_cnt_out,
`endif
   output logic [1:0]        state_out
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [DATA_W-1:0] r_instr;
   logic              r_instr_valid;
   logic              w_capture;
   logic              w_release;
   logic              w_pc_load;

   pc_next_calc #(
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W)
   ) u_pc_next_calc (
      .i_pc      (r_pc),
      .i_taken   (pc_ctl_0_in),
      .i_off     (br_off_in),
      .o_pc_next (w_pc_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clka or posedge reset_in) begin
      if (reset_in) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      w_pc_load   = 1'b0;
      case (r_state)
         IDLE:    w_state_nxt = REQ;
         REQ: begin
            if (imem_ack_in) begin
               w_state_nxt = ISSUE;
               w_capture   = 1'b1;
            end
         end
         ISSUE: begin
            if (instr_ready_in) begin
               w_state_nxt = RESOLVE;
               w_release   = 1'b1;
            end
         end
         RESOLVE: begin
            if (br_valid_in) begin
               w_state_nxt = REQ;
               w_pc_load   = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge reset_in) begin
      if (reset_in) begin
         r_pc          <= RESET_VEC;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
      end else begin
         if (w_capture) begin
            r_instr       <= imem_rdata_in;
            r_instr_valid <= 1'b1;
         end else if (w_release) begin
            r_instr_valid <= 1'b0;
         end
         if (w_pc_load) r_pc <= w_pc_next;
      end
   end

`ifdef PC_SEQ_BR_CNT_EN
   logic [15:0] r_br_cnt;

   // Saturating count of taken resolutions.
   always_ff @(posedge clka or posedge reset_in) begin
      if (reset_in)                                        r_br_cnt <= '0;
      else if (w_pc_load && pc_ctl_0_in && (r_br_cnt != 16'hFFFF)) r_br_cnt <= r_br_cnt + 16'd1;
   end

   assign br_taken_cnt_out = r_br_cnt;
`endif

   // Request and address follow the state register, so reset clears them at once.
   assign imem_req_out    = (r_state == REQ);
   assign imem_addr_out   = r_pc;
   assign instr_out       = r_instr;
   assign instr_valid_out = r_instr_valid;
   assign pc_out          = r_pc;
   assign state_out       = r_state;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: table of per-cycle vectors plus hand sequences
// for the address walk to 16'hFFFF, wrap-around and mid-request reset.
module tb_pc_seq;

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_REQ     = 2'b01;
   localparam logic [1:0] S_ISSUE   = 2'b10;
   localparam logic [1:0] S_RESOLVE = 2'b11;

   logic        clka = 1'b0;
   logic        reset_in;
   logic        imem_req_out;
   logic [15:0] imem_addr_out;
   logic        imem_ack_in;
   logic [15:0] imem_rdata_in;
   logic [15:0] instr_out;
   logic        instr_valid_out;
   logic        instr_ready_in;
   logic        br_valid_in;
   logic        pc_ctl_0_in;
   logic [8:0]  br_off_in;
   logic [15:0] pc_out;
   logic [1:0]  state_out;
`ifdef PC_SEQ_BR_CNT_EN
   logic [15:0] br_taken_cnt_out;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_cnt;
   logic [15:0] exp_pc;

   pc_seq dut (
      .clka            (clka),
      .reset_in        (reset_in),
      .imem_req_out    (imem_req_out),
      .imem_addr_out   (imem_addr_out),
      .imem_ack_in     (imem_ack_in),
      .imem_rdata_in   (imem_rdata_in),
      .instr_out       (instr_out),
      .instr_valid_out (instr_valid_out),
      .instr_ready_in  (instr_ready_in),
      .br_valid_in     (br_valid_in),
      .pc_ctl_0_in     (pc_ctl_0_in),
      .br_off_in       (br_off_in),
      .pc_out          (pc_out),
`ifdef PC_SEQ_BR_CNT_EN
      .br_taken_cnt_out(br_taken_cnt_out),
`endif
      .state_out       (state_out)
   );

   always #5 clka = ~clka;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        ack;
      logic [15:0] rd;
      logic        rdy;
      logic        brv;
      logic        tk;
      logic [8:0]  off;
      logic        e_req;
      logic [15:0] e_pc;
      logic        e_v;
      logic [15:0] e_i;
      logic [1:0]  e_st;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ack, logic [15:0] rd, logic rdy, logic brv, logic tk,
                               logic [8:0] off, logic e_req, logic [15:0] e_pc, logic e_v,
                               logic [15:0] e_i, logic [1:0] e_st, logic [15:0] e_cnt);
      vec_t v;
      v = '{ack, rd, rdy, brv, tk, off, e_req, e_pc, e_v, e_i, e_st, e_cnt};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [15:0] e_pc,
                             input logic e_v, input logic [15:0] e_i, input logic [1:0] e_st,
                             input logic [15:0] e_cnt);
      check({tag, " req"},   32'(imem_req_out),    32'(e_req));
      check({tag, " addr"},  32'(imem_addr_out),   32'(e_pc));
      check({tag, " pc"},    32'(pc_out),          32'(e_pc));
      check({tag, " valid"}, 32'(instr_valid_out), 32'(e_v));
      check({tag, " instr"}, 32'(instr_out),       32'(e_i));
      check({tag, " state"}, 32'(state_out),       32'(e_st));
`ifdef PC_SEQ_BR_CNT_EN
      check({tag, " cnt"},   32'(br_taken_cnt_out), 32'(e_cnt));
`endif
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ack_in    = 1'b0;
      imem_rdata_in  = 16'h0000;
      instr_ready_in = 1'b0;
      br_valid_in    = 1'b0;
      pc_ctl_0_in    = 1'b0;
      br_off_in      = 9'h000;
   endtask

   // Starting in REQ: zero-wait fetch, immediate accept, then resolve.
   task automatic fetch_resolve(input logic [15:0] word, input logic tk, input logic [8:0] off,
                                input logic [15:0] e_next);
      idle_inputs();
      imem_ack_in   = 1'b1;
      imem_rdata_in = word;
      step();
      check("walk issue instr", 32'(instr_out), 32'(word));
      idle_inputs();
      instr_ready_in = 1'b1;
      step();
      idle_inputs();
      br_valid_in = 1'b1;
      pc_ctl_0_in = tk;
      br_off_in   = off;
      step();
      if (tk) exp_cnt = exp_cnt + 16'd1;
      idle_inputs();
      check("walk state", 32'(state_out), 32'(S_REQ));
      check("walk addr",  32'(imem_addr_out), 32'(e_next));
`ifdef PC_SEQ_BR_CNT_EN
      check("walk cnt",   32'(br_taken_cnt_out), 32'(exp_cnt));
`endif
   endtask

   initial begin
      reset_in = 1'b1;
      idle_inputs();

      // Row inputs are held through the next edge; expectations are post-edge.
      vecs.push_back(mk(1, 16'h1111, 0, 0, 0, 9'h000, 1, 16'h3000, 0, 16'h0000, S_REQ,     0));
      vecs.push_back(mk(1, 16'hA001, 0, 0, 0, 9'h000, 0, 16'h3000, 1, 16'hA001, S_ISSUE,   0));
      vecs.push_back(mk(1, 16'hBEEF, 1, 1, 1, 9'h003, 0, 16'h3000, 0, 16'hA001, S_RESOLVE, 0));
      vecs.push_back(mk(1, 16'hBEEF, 1, 1, 0, 9'h000, 1, 16'h3001, 0, 16'hA001, S_REQ,     0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 16'hCCCC, 1, 1, 1, 9'h000, 1, 16'h3001, 0, 16'hA001, S_REQ, 0));
      vecs.push_back(mk(1, 16'hA002, 0, 0, 0, 9'h000, 0, 16'h3001, 1, 16'hA002, S_ISSUE,   0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1, 16'hDEAD, 0, 1, 1, 9'h000, 0, 16'h3001, 1, 16'hA002, S_ISSUE, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 9'h000, 0, 16'h3001, 0, 16'hA002, S_RESOLVE, 0));
      vecs.push_back(mk(1, 16'h7777, 1, 0, 1, 9'h003, 0, 16'h3001, 0, 16'hA002, S_RESOLVE, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 9'h003, 1, 16'h3005, 0, 16'hA002, S_REQ,     1));
      vecs.push_back(mk(1, 16'hA003, 0, 0, 0, 9'h000, 0, 16'h3005, 1, 16'hA003, S_ISSUE,   1));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 9'h000, 0, 16'h3005, 0, 16'hA003, S_RESOLVE, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 9'h1FE, 1, 16'h3004, 0, 16'hA003, S_REQ,     2));
      vecs.push_back(mk(1, 16'hA004, 0, 0, 0, 9'h000, 0, 16'h3004, 1, 16'hA004, S_ISSUE,   2));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 9'h000, 0, 16'h3004, 0, 16'hA004, S_RESOLVE, 2));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 9'h0FF, 1, 16'h3104, 0, 16'hA004, S_REQ,     3));
      vecs.push_back(mk(1, 16'hA005, 0, 0, 0, 9'h000, 0, 16'h3104, 1, 16'hA005, S_ISSUE,   3));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 9'h000, 0, 16'h3104, 0, 16'hA005, S_RESOLVE, 3));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 9'h0FF, 1, 16'h3105, 0, 16'hA005, S_REQ,     3));
      vecs.push_back(mk(1, 16'hA006, 0, 0, 0, 9'h000, 0, 16'h3105, 1, 16'hA006, S_ISSUE,   3));
      vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 9'h000, 0, 16'h3105, 0, 16'hA006, S_RESOLVE, 3));
      vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 9'h100, 1, 16'h3006, 0, 16'hA006, S_REQ,     4));

      repeat (3) @(posedge clka);
      #1;
      check_outs("reset", 0, 16'h3000, 0, 16'h0000, S_IDLE, 0);
      reset_in = 1'b0;
      #1;
      check("release state", 32'(state_out), 32'(S_IDLE));

      foreach (vecs[i]) begin
         imem_ack_in    = vecs[i].ack;
         imem_rdata_in  = vecs[i].rd;
         instr_ready_in = vecs[i].rdy;
         br_valid_in    = vecs[i].brv;
         pc_ctl_0_in    = vecs[i].tk;
         br_off_in      = vecs[i].off;
         step();
         check_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_v,
                    vecs[i].e_i, vecs[i].e_st, vecs[i].e_cnt);
      end
      idle_inputs();

      // Walk the PC up to 16'hFFFF in +256 steps, then exercise wrap both ways.
      exp_cnt = 16'd4;
      exp_pc  = 16'h3006;
      for (int k = 0; k < 'hCF; k++) begin
         exp_pc = exp_pc + 16'h0100;
         fetch_resolve(16'h5000 + 16'(k), 1'b1, 9'h0FF, exp_pc);
      end
      fetch_resolve(16'h6001, 1'b1, 9'h0F8, 16'hFFFF);
      fetch_resolve(16'h6002, 1'b1, 9'h000, 16'h0000);
      fetch_resolve(16'h6003, 1'b0, 9'h0AA, 16'h0001);
      fetch_resolve(16'h6004, 1'b1, 9'h1FD, 16'hFFFF);
`ifdef PC_SEQ_BR_CNT_EN
      check("taken total", 32'(br_taken_cnt_out), 32'd214);
`endif

      // Reset while waiting for an ack, then release with a stale ack present.
      step();
      check_outs("await ack", 1, 16'hFFFF, 0, 16'h6004, S_REQ, exp_cnt);
      #2;
      reset_in = 1'b1;
      #1;
      check_outs("async reset", 0, 16'h3000, 0, 16'h0000, S_IDLE, 0);
      step();
      check_outs("reset held", 0, 16'h3000, 0, 16'h0000, S_IDLE, 0);
      imem_ack_in   = 1'b1;
      imem_rdata_in = 16'hBAD1;
      reset_in      = 1'b0;
      step();
      check_outs("late ack", 1, 16'h3000, 0, 16'h0000, S_REQ, 0);
      step();
      check_outs("restart", 0, 16'h3000, 1, 16'hBAD1, S_ISSUE, 0);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
